// File: rtl/param_table_bank.sv
// param_table_bank: DEPTH-entry run-time constant table with shadow/active copies, commit copy and sticky lock.
// Optional per-entry dirty tracking is built when PARAM_TABLE_DIRTY_EN is defined.
module param_table_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int INIT_BASE = 555,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_err,
  input  logic             commit_req,
  output logic             commit_busy,
  output logic             commit_done,
  input  logic             lock,
  output logic             locked,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_data_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_err,
  output logic [DEPTH-1:0] dirty
);
  typedef enum logic {IDLE, COPY} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shadow [DEPTH];
  logic [WIDTH-1:0] active [DEPTH];
  logic wr_fire, rd_fire, wr_in, rd_in, wr_ok, last, start, done_d;
  assign commit_busy = state_q == COPY;
  assign wr_ready = !commit_busy;
  assign rd_ready = !commit_busy;
  assign wr_fire = wr_valid && wr_ready;
  assign rd_fire = rd_valid && rd_ready;
  assign wr_in = 32'(wr_addr) < DEPTH;
  assign rd_in = 32'(rd_addr) < DEPTH;
  assign wr_ok = wr_fire && wr_in && !locked;
  assign last = idx_q == AW'(DEPTH - 1);
  assign start = state_q == IDLE && commit_req && !locked;
  always_comb begin
    state_d = start ? COPY : (commit_busy && last) ? IDLE : state_q;
    idx_d = start ? '0 : commit_busy ? idx_q + AW'(1) : idx_q;
    done_d = commit_busy && last;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      commit_done <= 1'b0;
      locked <= 1'b0;
      wr_err <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_err <= 1'b0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      commit_done <= done_d;
      locked <= locked || lock;
      wr_err <= wr_fire && !(wr_in && !locked);
      rd_data_valid <= rd_fire;
      rd_err <= rd_fire && !rd_in;
      if (rd_fire) rd_data <= rd_in ? active[rd_addr] : '0;
    end
  end
  // Writes are stalled while copying, so shadow is stable for the whole copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow[i] <= WIDTH'(INIT_BASE + i);
        active[i] <= WIDTH'(INIT_BASE + i);
      end
    end else begin
      if (wr_ok) shadow[wr_addr] <= wr_data;
      if (commit_busy) active[idx_q] <= shadow[idx_q];
    end
  end
`ifdef PARAM_TABLE_DIRTY_EN
  logic [DEPTH-1:0] dirty_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dirty_q <= '0;
    else dirty_q <= (dirty_q | ({DEPTH{wr_ok}} & (DEPTH'(1) << wr_addr))) & ~({DEPTH{commit_busy}} & (DEPTH'(1) << idx_q));
  end
  assign dirty = dirty_q;
`else
  assign dirty = '0;
`endif
endmodule
